byte_pack_fifo: RTL and testbench

BYTE_PACK_FIFO -- requirements
Module: byte_pack_fifo

---
 rtl/byte_pack_pkg.sv | 15 +
 rtl/byte_pack_sync_fifo.sv | 52 +++++
 rtl/byte_pack_fifo.sv | 135 +++++++++++++
 tb/tb_byte_pack_fifo.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_pack_pkg.sv
// Shared types for the byte-to-halfword packing FIFO.
// Optional drop counter in the top is enabled by BYTE_PACK_DROP_COUNT_EN.
package byte_pack_pkg;

   localparam int unsigned DEFAULT_DEPTH = 16;

   typedef struct packed {
      logic [30:0] addr;
      logic [15:0] data;
      logic [1:0]  be;
   } hw_entry_t;

   typedef enum logic {StIdle, StReq} mem_state_e;

endpackage

// File: rtl/byte_pack_sync_fifo.sv
// Synchronous FIFO of packed halfword entries; caller guarantees no push when full
// without a simultaneous pop, and no pop when empty.
module byte_pack_sync_fifo
   import byte_pack_pkg::*;
#(
   parameter int unsigned Depth = DEFAULT_DEPTH
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  hw_entry_t              wdata_i,
   output hw_entry_t              rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(Depth):0] count_o
);

   localparam int unsigned PtrW = $clog2(Depth);

   hw_entry_t         mem_q [Depth];
   logic [PtrW-1:0]   wptr_q, rptr_q;
   logic [PtrW:0]     count_q;

   // Storage is not reset; only pointers and count define validity.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wptr_q] <= wdata_i;
   end

   // Depth is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_i) wptr_q <= wptr_q + 1'b1;
         if (pop_i)  rptr_q <= rptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign rdata_o = mem_q[rptr_q];
   assign full_o  = (count_q == (PtrW + 1)'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/byte_pack_fifo.sv
// Packs byte writes into halfword memory requests through a FIFO.
// Define BYTE_PACK_DROP_COUNT_EN to add the saturating drop_count output.
module byte_pack_fifo
   import byte_pack_pkg::*;
#(
   parameter int unsigned DEPTH        = DEFAULT_DEPTH,
   parameter bit          PUSH_ON_IDLE = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] in_address,
   input  logic [7:0]  in_data,
   input  logic        in_wr,
   output logic [31:0] mem_address,
   output logic [15:0] mem_data,
   output logic [1:0]  mem_be,
   output logic        mem_req,
   input  logic        mem_ack,
   output logic        overflow,
`ifdef BYTE_PACK_DROP_COUNT_EN
   output logic [15:0] drop_count,
`endif
   output logic        busy
);

   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   logic        pend_valid_q, pend_valid_d;
   logic [30:0] pend_addr_q, pend_addr_d;
   logic [15:0] pend_data_q, pend_data_d;
   logic [1:0]  pend_be_q, pend_be_d;
   logic        overflow_q;
   mem_state_e  state_q, state_d;

   logic            lane, merge, push_req, push_ok, pop, drop;
   logic            full, empty;
   logic [CntW-1:0] count;
   hw_entry_t       head, push_entry;

   assign lane  = in_address[0];
   assign merge = pend_valid_q & in_wr & (in_address[31:1] == pend_addr_q) & ~pend_be_q[lane];

   // Pending is flushed when complete, displaced by a non-merging byte, or on an idle cycle.
   assign push_req = pend_valid_q & ((pend_be_q == 2'b11) | (in_wr & ~merge) |
                                     (~in_wr & PUSH_ON_IDLE));
   assign pop      = (state_q == StReq) & mem_ack;
   assign push_ok  = push_req & (~full | pop);
   assign drop     = push_req & ~push_ok;

   assign push_entry = '{addr: pend_addr_q, data: pend_data_q, be: pend_be_q};

   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_addr_d  = pend_addr_q;
      pend_data_d  = pend_data_q;
      pend_be_d    = pend_be_q;
      if (in_wr && !merge) begin
         pend_valid_d = 1'b1;
         pend_addr_d  = in_address[31:1];
         pend_data_d  = lane ? {in_data, 8'h00} : {8'h00, in_data};
         pend_be_d    = lane ? 2'b10 : 2'b01;
      end else if (merge) begin
         if (lane) pend_data_d[15:8] = in_data;
         else      pend_data_d[7:0]  = in_data;
         pend_be_d[lane] = 1'b1;
      end else if (push_req) begin
         pend_valid_d = 1'b0;
         pend_be_d    = 2'b00;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (!empty) state_d = StReq;
         StReq:  if (mem_ack && (count == CntW'(1)) && !push_ok) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         pend_data_q  <= '0;
         pend_be_q    <= '0;
         overflow_q   <= 1'b0;
         state_q      <= StIdle;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         pend_data_q  <= pend_data_d;
         pend_be_q    <= pend_be_d;
         overflow_q   <= overflow_q | drop;
         state_q      <= state_d;
      end
   end

   byte_pack_sync_fifo #(
      .Depth (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .push_i  (push_ok),
      .pop_i   (pop),
      .wdata_i (push_entry),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

`ifdef BYTE_PACK_DROP_COUNT_EN
   logic [15:0] drop_cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         drop_cnt_q <= '0;
      end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign drop_count = drop_cnt_q;
`endif

   // Bus outputs are forced to zero outside a request so reset leaves them clean.
   assign mem_req     = (state_q == StReq);
   assign mem_address = mem_req ? {head.addr, 1'b0} : '0;
   assign mem_data    = mem_req ? head.data : '0;
   assign mem_be      = mem_req ? head.be : '0;
   assign overflow    = overflow_q;
   assign busy        = pend_valid_q | ~empty;

endmodule

// File: tb/tb_byte_pack_fifo.sv
// Self-checking bench for byte_pack_fifo: directed scenarios plus a random stream
// compared against a byte-collecting reference model.
module tb_byte_pack_fifo;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] in_address = '0;
   logic [7:0]  in_data = '0;
   logic        in_wr = 1'b0;
   logic [31:0] mem_address;
   logic [15:0] mem_data;
   logic [1:0]  mem_be;
   logic        mem_req;
   logic        mem_ack = 1'b0;
   logic        overflow;
   logic        busy;
`ifdef BYTE_PACK_DROP_COUNT_EN
   logic [15:0] drop_count;
`endif

   byte_pack_fifo dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_address  (in_address),
      .in_data     (in_data),
      .in_wr       (in_wr),
      .mem_address (mem_address),
      .mem_data    (mem_data),
      .mem_be      (mem_be),
      .mem_req     (mem_req),
      .mem_ack     (mem_ack),
      .overflow    (overflow),
`ifdef BYTE_PACK_DROP_COUNT_EN
      .drop_count  (drop_count),
`endif
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [15:0] data;
      logic [1:0]  be;
   } txn_t;

   txn_t got[$];
   txn_t expq[$];
   int   n_checks = 0;
   int   n_err = 0;

   // Reference: bytes collect into the current halfword; anything not joining it flushes it.
   bit          m_valid = 0;
   logic [30:0] m_hw;
   logic [7:0]  m_byte [2];
   bit          m_has [2];

   task automatic model_step(input bit wr, input logic [31:0] a, input logic [7:0] d);
      bit joins;
      txn_t t;
      joins = m_valid && wr && (a[31:1] == m_hw) && !m_has[a[0]];
      if (m_valid && !joins) begin
         t.addr = {m_hw, 1'b0};
         t.be   = {m_has[1], m_has[0]};
         t.data = {m_byte[1], m_byte[0]};
         expq.push_back(t);
         m_valid = 0;
      end
      if (joins) begin
         m_byte[a[0]] = d;
         m_has[a[0]]  = 1;
      end else if (wr) begin
         m_valid   = 1;
         m_hw      = a[31:1];
         m_has[0]  = 0;
         m_has[1]  = 0;
         m_byte[0] = 8'h00;
         m_byte[1] = 8'h00;
         m_byte[a[0]] = d;
         m_has[a[0]]  = 1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_txn(input string tag, input int idx, input logic [31:0] addr,
                            input logic [15:0] data, input logic [1:0] be);
      logic [15:0] mask;
      mask = {{8{be[1]}}, {8{be[0]}}};
      if (idx >= got.size()) begin
         n_checks++;
         n_err++;
         $error("FAIL %s: request %0d missing, observed count %0d", tag, idx, got.size());
      end else begin
         check({tag, "_addr"}, got[idx].addr, addr);
         check({tag, "_be"}, {30'd0, got[idx].be}, {30'd0, be});
         check({tag, "_data"}, {16'd0, got[idx].data & mask}, {16'd0, data & mask});
      end
   endtask

   // Drive one cycle at the falling edge; log any handshake; return just after the rising edge.
   task automatic step(input bit wr, input logic [31:0] a, input logic [7:0] d, input bit ack);
      txn_t t;
      @(negedge clk);
      if (mem_req === 1'b1 && ack) begin
         t.addr = mem_address;
         t.data = mem_data;
         t.be   = mem_be;
         got.push_back(t);
      end
      in_wr      = wr;
      in_address = a;
      in_data    = d;
      mem_ack    = ack;
      model_step(wr, a, d);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      got.delete();
      expq.delete();
      m_valid = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      in_wr   = 1'b0;
      mem_ack = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      clear_logs();
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_mem_be", {30'd0, mem_be}, 32'd0);
      check("rst_mem_address", mem_address, 32'd0);
      check("rst_mem_data", {16'd0, mem_data}, 32'd0);
`ifdef BYTE_PACK_DROP_COUNT_EN
      check("rst_drop_count", {16'd0, drop_count}, 32'd0);
`endif
      do_reset();

      // Latency: complete halfword to mem_req is two cycles
      step(1, 32'h100, 8'h11, 0);
      step(1, 32'h101, 8'h22, 0);
      check("lat_c0_req", {31'd0, mem_req}, 32'd0);
      step(0, 32'h0, 8'h00, 0);
      check("lat_c1_req", {31'd0, mem_req}, 32'd0);
      check("lat_c1_busy", {31'd0, busy}, 32'd1);
      step(0, 32'h0, 8'h00, 0);
      check("lat_c2_req", {31'd0, mem_req}, 32'd1);
      check("lat_addr", mem_address, 32'h100);
      check("lat_data", {16'd0, mem_data}, 32'h2211);
      check("lat_be", {30'd0, mem_be}, 32'd3);
      step(0, 32'h0, 8'h00, 1);
      check("lat_done_req", {31'd0, mem_req}, 32'd0);
      check("lat_done_busy", {31'd0, busy}, 32'd0);

      // Four consecutive bytes -> two full halfwords
      do_reset();
      step(1, 32'h100, 8'h11, 0);
      step(1, 32'h101, 8'h22, 0);
      step(1, 32'h102, 8'h33, 0);
      step(1, 32'h103, 8'h44, 0);
      repeat (8) step(0, 32'h0, 8'h00, 1);
      check("seq4_count", got.size(), 32'd2);
      check_txn("seq4_t0", 0, 32'h100, 16'h2211, 2'b11);
      check_txn("seq4_t1", 1, 32'h102, 16'h4433, 2'b11);

      // Single upper-lane byte flushed on idle
      do_reset();
      step(1, 32'h205, 8'hAB, 0);
      repeat (6) step(0, 32'h0, 8'h00, 1);
      check("single_count", got.size(), 32'd1);
      check_txn("single_t0", 0, 32'h204, 16'hAB00, 2'b10);

      // Same lane twice -> two separate requests
      do_reset();
      step(1, 32'h10, 8'h01, 0);
      step(1, 32'h10, 8'h02, 0);
      repeat (8) step(0, 32'h0, 8'h00, 1);
      check("samelane_count", got.size(), 32'd2);
      check_txn("samelane_t0", 0, 32'h10, 16'h0001, 2'b01);
      check_txn("samelane_t1", 1, 32'h10, 16'h0002, 2'b01);

      // Overflow: 18 halfwords with ack held low
      do_reset();
      for (int i = 0; i < 18; i++) begin
         step(1, 32'h1000 + 32'(2 * i), 8'(i), 0);
         step(1, 32'h1001 + 32'(2 * i), 8'(i + 8'h80), 0);
      end
      step(0, 32'h0, 8'h00, 0);
      step(0, 32'h0, 8'h00, 0);
      check("ovf_flag", {31'd0, overflow}, 32'd1);
      check("ovf_req", {31'd0, mem_req}, 32'd1);
      check("ovf_head", mem_address, 32'h1000);
`ifdef BYTE_PACK_DROP_COUNT_EN
      check("ovf_drop_count", {16'd0, drop_count}, 32'd2);
`endif
      repeat (40) step(0, 32'h0, 8'h00, 1);
      check("ovf_queued", got.size(), 32'd16);
      check_txn("ovf_first", 0, 32'h1000, 16'h8000, 2'b11);
      check_txn("ovf_last", 15, 32'h101E, 16'h8F0F, 2'b11);
      check("ovf_sticky", {31'd0, overflow}, 32'd1);

      // Full FIFO with push and ack in the same cycle
      do_reset();
      for (int i = 0; i < 16; i++) begin
         step(1, 32'h2000 + 32'(2 * i), 8'(i), 0);
         step(1, 32'h2001 + 32'(2 * i), 8'(i + 8'h80), 0);
      end
      step(0, 32'h0, 8'h00, 0);
      check("full_no_ovf", {31'd0, overflow}, 32'd0);
      step(1, 32'h2020, 8'hA0, 0);
      step(1, 32'h2021, 8'hA1, 0);
      step(0, 32'h0, 8'h00, 1);
      check("full_pushpop_ovf", {31'd0, overflow}, 32'd0);
      repeat (40) step(0, 32'h0, 8'h00, 1);
      check("full_total", got.size(), 32'd17);
      check_txn("full_first", 0, 32'h2000, 16'h8000, 2'b11);
      check_txn("full_last", 16, 32'h2020, 16'hA1A0, 2'b11);

      // Reset mid-request with three entries queued
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(1, 32'h3000 + 32'(2 * i), 8'h5A, 0);
         step(1, 32'h3001 + 32'(2 * i), 8'hA5, 0);
      end
      step(0, 32'h0, 8'h00, 0);
      step(0, 32'h0, 8'h00, 0);
      check("midrst_pre_req", {31'd0, mem_req}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_req", {31'd0, mem_req}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_be", {30'd0, mem_be}, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      clear_logs();
      repeat (10) step(0, 32'h0, 8'h00, 1);
      check("midrst_no_req", got.size(), 32'd0);
      check("midrst_idle", {31'd0, mem_req}, 32'd0);

      // Random stream against the reference model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step(bit'($urandom_range(1, 0)), 32'h40 + 32'($urandom_range(5, 0)),
              8'($urandom), ($urandom_range(7, 0) != 0));
      end
      repeat (60) step(0, 32'h0, 8'h00, 1);
      check("rand_count", got.size(), expq.size());
      for (int i = 0; i < expq.size(); i++) begin
         check_txn($sformatf("rand_t%0d", i), i, expq[i].addr, expq[i].data, expq[i].be);
      end
      check("rand_no_ovf", {31'd0, overflow}, 32'd0);
      check("rand_idle_busy", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
